// File: rtl/tcdm_bank_responder_if.sv
// Bundles for one TCDM bank: the interconnect-side request/response stream
// and the single-port synchronous SRAM macro port.
interface tcdm_bank_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
    logic [ID_WIDTH-1:0]   id;
    logic [USER_WIDTH-1:0] user;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ID_WIDTH-1:0]   r_id;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_opc;

    modport master (
        output req, add, wen, data, be, id, user,
        input  gnt, r_valid, r_data, r_id, r_user, r_opc
    );
    modport slave (
        input  req, add, wen, data, be, id, user,
        output gnt, r_valid, r_data, r_id, r_user, r_opc
    );
endinterface

interface tcdm_mem_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned ADDR_MEM_WIDTH = 11
);
    logic                      req;
    logic                      we;
    logic [ADDR_MEM_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [BE_WIDTH-1:0]       be;
    logic [DATA_WIDTH-1:0]     rdata;

    modport master (output req, we, addr, wdata, be, input rdata);
    modport slave  (input req, we, addr, wdata, be, output rdata);
endinterface

// File: rtl/tcdm_bank_responder.sv
// Bank-side TCDM target driving a single-port SRAM; the test-and-set atomic
// (read then write all-ones) is built only when TCDM_BANK_TEST_SET_EN is defined.
module tcdm_bank_responder #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ADDR_MEM_WIDTH = 11,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned USER_WIDTH     = 1,
    parameter int unsigned TS_BIT         = 20
) (
    input  logic      clk_i,
    input  logic      rst_i,
    tcdm_bank_if.slave bus,
    tcdm_mem_if.master mem
);

    logic                      accept_s;
    logic                      gnt_s;
    logic                      mem_req_s;
    logic                      mem_we_s;
    logic [ADDR_MEM_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0]     mem_wdata_s;
    logic [BE_WIDTH-1:0]       mem_be_s;
    logic [ADDR_MEM_WIDTH-1:0] req_word_s;

    logic                      r_valid_r;
    logic                      rd_sel_r;
    logic [ID_WIDTH-1:0]       r_id_r;
    logic [USER_WIDTH-1:0]     r_user_r;

    assign req_word_s = bus.add[ADDR_MEM_WIDTH+1:2];
    assign accept_s   = bus.req & gnt_s;

`ifdef TCDM_BANK_TEST_SET_EN
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TS_WB = 1'b1
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [ADDR_MEM_WIDTH-1:0] ts_addr_r;

    // State register and captured test-and-set word address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            ts_addr_r <= {ADDR_MEM_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s && bus.wen && bus.add[TS_BIT]) begin
                ts_addr_r <= req_word_s;
            end else begin
                ts_addr_r <= ts_addr_r;
            end
        end
    end

    // Next state and SRAM port: pass-through in IDLE, all-ones write-back in TS_WB.
    always_comb begin
        state_s     = IDLE;
        gnt_s       = 1'b1;
        mem_req_s   = bus.req;
        mem_we_s    = ~bus.wen;
        mem_addr_s  = req_word_s;
        mem_wdata_s = bus.data;
        mem_be_s    = bus.be;
        case (state_r)
            IDLE: begin
                if (bus.req && bus.wen && bus.add[TS_BIT]) begin
                    state_s = TS_WB;
                end else begin
                    state_s = IDLE;
                end
            end
            TS_WB: begin
                state_s     = IDLE;
                gnt_s       = 1'b0;
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = ts_addr_r;
                mem_wdata_s = {DATA_WIDTH{1'b1}};
                mem_be_s    = {BE_WIDTH{1'b1}};
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end
`else
    // Without test-and-set the bank never stalls and TS_BIT carries no meaning.
    always_comb begin
        gnt_s       = 1'b1;
        mem_req_s   = bus.req;
        mem_we_s    = ~bus.wen;
        mem_addr_s  = req_word_s;
        mem_wdata_s = bus.data;
        mem_be_s    = bus.be;
    end
`endif

    // One response per accepted request, exactly one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_r <= 1'b0;
            rd_sel_r  <= 1'b0;
            r_id_r    <= {ID_WIDTH{1'b0}};
            r_user_r  <= {USER_WIDTH{1'b0}};
        end else begin
            r_valid_r <= accept_s;
            rd_sel_r  <= accept_s & bus.wen;
            if (accept_s) begin
                r_id_r   <= bus.id;
                r_user_r <= bus.user;
            end else begin
                r_id_r   <= r_id_r;
                r_user_r <= r_user_r;
            end
        end
    end

    assign bus.gnt     = gnt_s;
    assign bus.r_valid = r_valid_r;
    // The SRAM output register already provides the response cycle for reads.
    assign bus.r_data  = rd_sel_r ? mem.rdata : {DATA_WIDTH{1'b0}};
    assign bus.r_id    = r_id_r;
    assign bus.r_user  = r_user_r;
    assign bus.r_opc   = 1'b0;

    assign mem.req   = mem_req_s;
    assign mem.we    = mem_we_s;
    assign mem.addr  = mem_addr_s;
    assign mem.wdata = mem_wdata_s;
    assign mem.be    = mem_be_s;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Scoreboard bench for tcdm_bank_responder: word-level reference memory,
// behavioural SRAM, directed cases followed by random traffic.
module tb_tcdm_bank_responder;

`ifdef TCDM_BANK_TEST_SET_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0]  id;
        logic        user;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcdm_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .USER_WIDTH(1)) bus ();
    tcdm_mem_if  #(.DATA_WIDTH(32), .ADDR_MEM_WIDTH(11)) mem ();

    tcdm_bank_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ADDR_MEM_WIDTH(11),
        .ID_WIDTH(8), .USER_WIDTH(1), .TS_BIT(20)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus),
        .mem  (mem)
    );

    logic [31:0] sram    [0:2047];
    logic [31:0] ref_mem [0:2047];
    exp_t        sb [$];
    int          checks   = 0;
    int          errors   = 0;
    int          resp_cnt = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural SRAM: byte-enabled write, read data registered one cycle.
    always @(posedge clk) begin
        if (mem.req) begin
            if (mem.we) sram[mem.addr] <= merge(sram[mem.addr], mem.wdata, mem.be);
            else        mem.rdata      <= sram[mem.addr];
        end
    end

    // Reference model applied at the moment a request is accepted.
    task automatic model_accept(input logic wen, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [7:0] id, input logic user);
        exp_t e;
        int   w;
        w      = (a >> 2) % 2048;
        e.id   = id;
        e.user = user;
        if (wen) begin
            e.data = ref_mem[w];
            if (TS_EN && a[20]) ref_mem[w] = 32'hFFFF_FFFF;
        end else begin
            e.data     = 32'h0;
            ref_mem[w] = merge(ref_mem[w], d, be);
        end
        sb.push_back(e);
    endtask

    // Monitor: every response is compared with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && bus.r_valid) begin
            resp_cnt++;
            check("r_opc", {31'h0, bus.r_opc}, 32'h0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got id %h expected no response", bus.r_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("r_id", {24'h0, bus.r_id}, {24'h0, e.id});
                check("r_user", {31'h0, bus.r_user}, {31'h0, e.user});
                check("r_data", bus.r_data, e.data);
            end
        end
    end

    task automatic issue(input logic wen, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [7:0] id, output int stalls);
        logic usr;
        bit   done;
        usr      = 1'($urandom);
        bus.req  = 1'b1;
        bus.wen  = wen;
        bus.add  = a;
        bus.data = d;
        bus.be   = be;
        bus.id   = id;
        bus.user = usr;
        stalls   = 0;
        done     = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (bus.gnt) begin
                model_accept(wen, a, d, be, id, usr);
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("grant_timeout", 32'(stalls), 32'h0);
    endtask

    task automatic idle();
        bus.req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          st, st1, st2, sum;
        int          base;
        logic [31:0] a;
        for (int i = 0; i < 2048; i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bus.req = 1'b0; bus.wen = 1'b1; bus.add = 32'h0; bus.data = 32'h0;
        bus.be  = 4'h0; bus.id  = 8'h0; bus.user = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_r_valid", {31'h0, bus.r_valid}, 32'h0);
        check("rst_r_data", bus.r_data, 32'h0);
        check("rst_r_id", {24'h0, bus.r_id}, 32'h0);
        check("rst_r_user", {31'h0, bus.r_user}, 32'h0);
        check("rst_gnt", {31'h0, bus.gnt}, 32'h1);
        check("rst_mem_req", {31'h0, mem.req}, 32'h0);
        rst = 1'b0;
        idle();

        // Full write, byte-masked write, reads in between.
        issue(1'b0, 32'h14, 32'hDEADBEEF, 4'hF, 8'h11, st); idle();
        issue(1'b1, 32'h14, 32'h0, 4'h0, 8'h12, st); idle();
        issue(1'b0, 32'h14, 32'h000000AA, 4'h1, 8'h13, st); idle();
        issue(1'b1, 32'h14, 32'h0, 4'h0, 8'h14, st); idle();

        // Ten back-to-back reads.
        base = resp_cnt;
        sum  = 0;
        for (int i = 0; i < 10; i++) begin
            issue(1'b1, 32'(i * 4), 32'h0, 4'h0, 8'(i), st);
            sum += st;
        end
        idle(); idle();
        check("b2b_stalls", 32'(sum), 32'h0);
        check("b2b_resp_cnt", 32'(resp_cnt - base), 32'd10);

        // Test-and-set of word 7 with a plain read held behind it.
        issue(1'b0, 32'h1C, 32'h0, 4'hF, 8'h20, st); idle();
        issue(1'b1, 32'h0010_001C, 32'h0, 4'h0, 8'h21, st1);
        issue(1'b1, 32'h1C, 32'h0, 4'h0, 8'h22, st2);
        idle(); idle();
        check("ts_first_stall", 32'(st1), 32'h0);
        check("ts_hold_stall", 32'(st2), TS_EN ? 32'h1 : 32'h0);

        // Reset during the write-back cycle of a test-and-set on word 9.
        issue(1'b0, 32'h24, 32'h12345678, 4'hF, 8'h30, st); idle(); idle();
        bus.req = 1'b1; bus.wen = 1'b1; bus.add = 32'h0010_0024; bus.id = 8'h31;
        @(negedge clk);
        check("rstts_gnt", {31'h0, bus.gnt}, 32'h1);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        rst     = 1'b1;
        #1;
        check("rstts_r_valid", {31'h0, bus.r_valid}, 32'h0);
        check("rstts_gnt_idle", {31'h0, bus.gnt}, 32'h1);
        check("rstts_mem_req", {31'h0, mem.req}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        issue(1'b1, 32'h24, 32'h0, 4'h0, 8'h32, st); idle(); idle();

        // TS_BIT on a write is ignored: plain write, no stall for the following read.
        issue(1'b0, 32'h0010_0014, 32'hCAFEF00D, 4'hF, 8'h40, st1);
        issue(1'b1, 32'h14, 32'h0, 4'h0, 8'h41, st2);
        idle(); idle();
        check("tswr_stalls", 32'(st1 + st2), 32'h0);

        // Random traffic over a small word range with junk in ignored address bits.
        for (int n = 0; n < 300; n++) begin
            a       = $urandom;
            a[12:2] = 11'($urandom_range(0, 15));
            a[20]   = ($urandom_range(0, 3) == 0);
            issue(1'($urandom), a, $urandom, 4'($urandom), 8'($urandom), st);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        check("drain", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_responder.md
Name: tcdm_bank_responder

Overview:
- Bank-side target for one TCDM bank: accepts an HCI-style request stream from one interconnect memory initiator port and drives a single-port synchronous SRAM macro.
- Returns the response stream (r_valid, r_data, r_id, r_user, r_opc) to the interconnect.
- Implements the test-and-set atomic selected by address bit TS_BIT as a two-cycle read-modify-write.
- Instantiated once per bank between the cluster interconnect and the SRAM.

Parameters:
- DATA_WIDTH, 32, data width in bits; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ADDR_WIDTH, 32, request address width in bits (byte address).
- ADDR_MEM_WIDTH, 11, SRAM word-address width.
- ID_WIDTH, 8, request/response ID width.
- USER_WIDTH, 1, user sideband width; must be at least 1.
- TS_BIT, 20, address bit that selects test-and-set.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_i  in  1  request valid
- gnt_o  out  1  request grant
- add_i  in  ADDR_WIDTH  byte address
- wen_i  in  1  1 = read, 0 = write
- data_i  in  DATA_WIDTH  write data
- be_i  in  BE_WIDTH  byte enables
- id_i  in  ID_WIDTH  transaction ID
- user_i  in  USER_WIDTH  user sideband
- r_valid_o  out  1  response valid
- r_data_o  out  DATA_WIDTH  read data
- r_id_o  out  ID_WIDTH  response ID
- r_user_o  out  USER_WIDTH  response user
- r_opc_o  out  1  error flag; always 0
- mem_req_o  out  1  SRAM chip enable
- mem_we_o  out  1  SRAM write enable, 1 = write
- mem_addr_o  out  ADDR_MEM_WIDTH  SRAM word address = add_i[ADDR_MEM_WIDTH+1:2]
- mem_wdata_o  out  DATA_WIDTH  SRAM write data
- mem_be_o  out  BE_WIDTH  SRAM byte enables
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after a read access

Behaviour:
- Reset values:
  - All registered outputs are 0: r_valid_o, r_data_o, r_id_o, r_user_o, r_opc_o.
  - FSM goes to IDLE.
  - gnt_o = 1 and mem_req_o = 0 whenever req_i = 0.
- FSM states: IDLE, TS_WB.
- IDLE:
  - gnt_o = 1; combinational pass-through: mem_req_o = req_i, mem_we_o = ~wen_i, mem_wdata_o = data_i, mem_be_o = be_i.
  - A request is accepted when req_i & gnt_o.
  - Accepted read or write: the next cycle asserts r_valid_o for 1 cycle with r_id_o/r_user_o captured from the request. Responses are unconditional; there is no r_ready.
  - r_data_o:
    - Read: r_data_o = mem_rdata_i. This is a direct path, since the SRAM latency already supplies the cycle.
    - Write: r_data_o = 0.
  - Accepted read with add_i[TS_BIT] = 1 (test-and-set):
    - Performs a normal SRAM read.
    - Captures the word address into the TS address register.
    - Moves to TS_WB.
  - A write with add_i[TS_BIT] = 1 is an ordinary write; TS_BIT is ignored.
- TS_WB (exactly 1 cycle):
  - gnt_o = 0; req_i is not accepted.
  - mem_req_o = 1, mem_we_o = 1, mem_addr_o = captured address, mem_wdata_o = all ones, mem_be_o = all ones.
  - r_valid_o = 1 with the old word (mem_rdata_i).
  - Next state: IDLE.
- Back-to-back operation:
  - Full throughput of one request per cycle in IDLE.
  - Read after write to the same address returns the new data (SRAM write-first is not required; the ordering is guaranteed by the cycle separation).
- Request held across TS_WB: the request stays pending (req_i is high, gnt_o is low) and is granted the cycle after.
- Reset asserted mid-TS_WB:
  - FSM returns to IDLE immediately; the write-back is abandoned.
  - r_valid_o is cleared.
- mem_addr_o ignores add_i bits [1:0] and all bits above ADDR_MEM_WIDTH+1, including TS_BIT.
- r_opc_o is tied to 0.

Optional Feature:
- Macro: TCDM_BANK_TEST_SET_EN.
- Defined: test-and-set is supported exactly as above.
- Undefined:
  - No TS_WB state is built and gnt_o is constant 1.
  - add_i[TS_BIT] is ignored, so a TS read behaves as a plain read.
  - No SRAM write-back occurs.

Test Plan:
- Reset, then write 0xDEADBEEF with be = 0xF to word 5 → r_valid_o = 1 next cycle with r_data_o = 0 and the echoed ID; a subsequent read of word 5 returns 0xDEADBEEF one cycle after grant.
- Write 0x000000AA with be = 0x1 to word 5 (holding 0xDEADBEEF) → a read returns 0xDEADBEAA.
- Ten back-to-back reads with IDs 0..9 → gnt_o stays high; ten consecutive r_valid_o pulses carry IDs in order.
- TS read of word 7 (holding 0x00000000), with req_i held for a following plain read of word 7 → gnt_o low for 1 cycle; the first response is 0x00000000; the second response is 0xFFFFFFFF. With TCDM_BANK_TEST_SET_EN undefined → both responses are 0x00000000 and gnt_o never drops.
- Assert rst_i during TS_WB → no write to the SRAM, r_valid_o = 0 and FSM in IDLE; a read of the word returns its pre-TS value.
- Address 0x0010_0014 (bit 20 set, with TS_BIT = 20) on a write → an ordinary write to word 5; no extra cycle.
